dmem_arbiter: RTL and testbench

//  Shares the single-port 1024x32 data RAM between the CPU data port and a debug/loader port.
//  Per-cycle round-robin arbitration, plus a debug lock that holds the CPU off during program load.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/rd_tag_pipe.sv | 22 ++
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory path: port identity, RAM command and read-return owner tag.
package riscv_mem_pkg;
  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {PORT_CPU, PORT_DBG} port_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic  v;
    port_e port;
  } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency; async clear drops in-flight reads.
module rd_tag_pipe import riscv_mem_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t [RD_LAT-1:0] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[RD_LAT-1];
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between CPU and debug/loader ports,
// with a debug lock and tag-routed pipelined read returns.
module dmem_arbiter import riscv_mem_pkg::*; #(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  port_e       rr_last;
  logic        lock_q, lock_eff;
  logic        cpu_elig, dbg_elig;
  mem_cmd_t    cmd;
  rd_tag_t     tag_in, tag_out;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // Lock applies immediately on rise but lingers one cycle after it drops.
  assign lock_eff = dbg_lock | lock_q;
  // Grants are masked while reset is held so nothing reaches the RAM.
  assign cpu_elig = rst_n & cpu_req & ~lock_eff;
  assign dbg_elig = rst_n & dbg_req;

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (cpu_elig && dbg_elig) begin
      if (rr_last == PORT_DBG) cpu_gnt = 1'b1;
      else                     dbg_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_elig;
      dbg_gnt = dbg_elig;
    end
  end

  always_comb begin
    cmd = '0;
    if (cpu_gnt)      cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    else if (dbg_gnt) cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  end

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign tag_in.v    = mem_en & ~cmd.we;
  assign tag_in.port = dbg_gnt ? PORT_DBG : PORT_CPU;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign cpu_rvalid = tag_out.v & (tag_out.port == PORT_CPU);
  assign dbg_rvalid = tag_out.v & (tag_out.port == PORT_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last     <= PORT_DBG;
      lock_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      lock_q <= dbg_lock;
      if (cpu_gnt)      rr_last <= PORT_CPU;
      else if (dbg_gnt) rr_last <= PORT_DBG;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a write-first 1-cycle RAM model.
module tb_dmem_arbiter;
  import riscv_mem_pkg::*;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM macro model: write-first, one cycle read latency
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        ram_q         <= mem_wdata;
      end else begin
        ram_q <= ram[mem_addr];
      end
    end
  end
  assign mem_rdata = ram_q;

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          lk;
    logic          cg, dg, st, crv, drv, men, mwe;
    logic [AW-1:0] ma;
    logic [DW-1:0] crd, drd;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic void v(
    input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
    input logic lk,
    input logic cg, input logic dg, input logic st, input logic crv, input logic drv,
    input logic men, input logic mwe, input logic [AW-1:0] ma,
    input logic [DW-1:0] crd, input logic [DW-1:0] drd);
    vec_t t;
    t.cr = cr; t.cw = cw; t.ca = ca; t.cd = cd;
    t.dr = dr; t.dw = dw; t.da = da; t.dd = dd; t.lk = lk;
    t.cg = cg; t.dg = dg; t.st = st; t.crv = crv; t.drv = drv;
    t.men = men; t.mwe = mwe; t.ma = ma; t.crd = crd; t.drd = drd;
    vq.push_back(t);
  endfunction

  task automatic drive(input vec_t t);
    cpu_req = t.cr; cpu_we = t.cw; cpu_addr = t.ca; cpu_wdata = t.cd;
    dbg_req = t.dr; dbg_we = t.dw; dbg_addr = t.da; dbg_wdata = t.dd;
    dbg_lock = t.lk;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 | i;
    ram[5] = 32'h0BADF00D;
    ram_q  = '0;

    // reset held with both ports requesting
    rst_n = 1'b0;
    idle();
    cpu_req = 1; cpu_addr = 10'h010; dbg_req = 1; dbg_addr = 10'h020;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_cpu_gnt", 0, cpu_gnt, 0);
    chk("rst_dbg_gnt", 0, dbg_gnt, 0);
    chk("rst_cpu_rvalid", 0, cpu_rvalid, 0);
    chk("rst_dbg_rvalid", 0, dbg_rvalid, 0);
    chk("rst_mem_en", 0, mem_en, 0);
    chk("rst_mem_we", 0, mem_we, 0);

    // contention: first tie to CPU, then strict alternation
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  1,0,0,0,0, 1,0,10'h010, 32'h0,         32'h0);
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  0,1,1,1,0, 1,0,10'h020, 32'hA000_0010, 32'h0);
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  1,0,0,0,1, 1,0,10'h010, 32'hA000_0010, 32'hA000_0020);
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  0,1,1,1,0, 1,0,10'h020, 32'hA000_0010, 32'hA000_0020);
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  1,0,0,0,1, 1,0,10'h010, 32'hA000_0010, 32'hA000_0020);
    v(1,0,10'h010,0, 1,0,10'h020,0, 0,  0,1,1,1,0, 1,0,10'h020, 32'hA000_0010, 32'hA000_0020);
    // lone CPU read of 0x005
    v(1,0,10'h005,0, 0,0,10'h000,0, 0,  1,0,0,0,1, 1,0,10'h005, 32'hA000_0010, 32'hA000_0020);
    v(0,0,10'h000,0, 0,0,10'h000,0, 0,  0,0,0,1,0, 0,0,10'h000, 32'h0BADF00D, 32'hA000_0020);
    // debug lock: program load while CPU waits
    v(1,0,10'h005,0, 1,1,10'h000,32'h00100113, 1,  0,1,1,0,0, 1,1,10'h000, 32'h0BADF00D, 32'hA000_0020);
    v(1,0,10'h005,0, 1,1,10'h001,32'h00200193, 1,  0,1,1,0,0, 1,1,10'h001, 32'h0BADF00D, 32'hA000_0020);
    v(1,0,10'h005,0, 1,1,10'h002,32'h00300213, 1,  0,1,1,0,0, 1,1,10'h002, 32'h0BADF00D, 32'hA000_0020);
    v(1,0,10'h005,0, 1,1,10'h003,32'h00400293, 1,  0,1,1,0,0, 1,1,10'h003, 32'h0BADF00D, 32'hA000_0020);
    v(1,0,10'h005,0, 0,0,10'h000,0, 0,  0,0,1,0,0, 0,0,10'h000, 32'h0BADF00D, 32'hA000_0020);
    v(1,0,10'h005,0, 0,0,10'h000,0, 0,  1,0,0,0,0, 1,0,10'h005, 32'h0BADF00D, 32'hA000_0020);
    // CPU write 0x3FF then debug read-back
    v(1,1,10'h3FF,32'hDEADBEEF, 0,0,10'h000,0, 0,  1,0,0,1,0, 1,1,10'h3FF, 32'h0BADF00D, 32'hA000_0020);
    v(0,0,10'h000,0, 1,0,10'h3FF,0, 0,  0,1,0,0,0, 1,0,10'h3FF, 32'h0BADF00D, 32'hA000_0020);
    v(0,0,10'h000,0, 0,0,10'h000,0, 0,  0,0,0,0,1, 0,0,10'h000, 32'h0BADF00D, 32'hDEADBEEF);
    // loaded word readable
    v(0,0,10'h000,0, 1,0,10'h002,0, 0,  0,1,0,0,0, 1,0,10'h002, 32'h0BADF00D, 32'hDEADBEEF);
    v(0,0,10'h000,0, 0,0,10'h000,0, 0,  0,0,0,0,1, 0,0,10'h000, 32'h0BADF00D, 32'h00300213);
    // lock rises with a CPU read in flight
    v(1,0,10'h011,0, 0,0,10'h000,0, 0,  1,0,0,0,0, 1,0,10'h011, 32'h0BADF00D, 32'h00300213);
    v(0,0,10'h000,0, 1,0,10'h012,0, 1,  0,1,0,1,0, 1,0,10'h012, 32'hA000_0011, 32'h00300213);
    v(0,0,10'h000,0, 0,0,10'h000,0, 1,  0,0,0,0,1, 0,0,10'h000, 32'hA000_0011, 32'hA000_0012);
    v(0,0,10'h000,0, 0,0,10'h000,0, 0,  0,0,0,0,0, 0,0,10'h000, 32'hA000_0011, 32'hA000_0012);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vq[i]);
      #2;
      chk("cpu_gnt",    i, cpu_gnt,    vq[i].cg);
      chk("dbg_gnt",    i, dbg_gnt,    vq[i].dg);
      chk("cpu_stall",  i, cpu_stall,  vq[i].st);
      chk("cpu_rvalid", i, cpu_rvalid, vq[i].crv);
      chk("dbg_rvalid", i, dbg_rvalid, vq[i].drv);
      chk("mem_en",     i, mem_en,     vq[i].men);
      chk("mem_we",     i, mem_we,     vq[i].mwe);
      chk("mem_addr",   i, mem_addr,   vq[i].ma);
      chk("cpu_rdata",  i, cpu_rdata,  vq[i].crd);
      chk("dbg_rdata",  i, dbg_rdata,  vq[i].drd);
    end

    // reset asserted the cycle after a CPU read grant
    @(negedge clk);
    idle();
    cpu_req = 1; cpu_addr = 10'h005;
    #2;
    chk("t6_cpu_gnt", 0, cpu_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 0;
    #2;
    chk("t6_rst_cpu_rvalid", 0, cpu_rvalid, 0);
    chk("t6_rst_mem_en", 0, mem_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t6_cpu_rvalid", k, cpu_rvalid, 0);
      chk("t6_dbg_rvalid", k, dbg_rvalid, 0);
      @(negedge clk);
    end
    // tie after reset goes to the CPU again
    cpu_req = 1; cpu_addr = 10'h010; dbg_req = 1; dbg_addr = 10'h020;
    #2;
    chk("t6_tie_cpu_gnt", 0, cpu_gnt, 1);
    chk("t6_tie_dbg_gnt", 0, dbg_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
